// File: rtl/cpu_defs_pkg.sv
//------------------------------------------------------------------------------
// cpu_defs_pkg : shared write-back select / load-type encodings for the core
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_defs_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_MDU  = 2'd3
  } wbsel_e;

  // Encodings 5-7 are not listed and behave as LD_W.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ldtype_e;

  localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

`default_nettype wire

// File: rtl/mw_writeback_if.sv
//------------------------------------------------------------------------------
// mw_writeback_if : M-stage inputs and W-stage register-file/forwarding outputs
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mw_writeback_if;

  logic        Flush;
  logic        Valid_M;
  logic [31:0] PC_M;
  logic [4:0]  A3_M;
  logic [1:0]  WBSel_M;
  logic [2:0]  LoadType_M;
  logic [31:0] ALUOut_M;
  logic [31:0] MDUOut_M;
  logic [31:0] MemRD_M;

  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic [31:0] WPC_W;
  logic [4:0]  FwdA3_W;
  logic [31:0] FwdData_W;

  modport master (
    output Flush, Valid_M, PC_M, A3_M, WBSel_M, LoadType_M,
           ALUOut_M, MDUOut_M, MemRD_M,
    input  A3_W, WD_W, WPC_W, FwdA3_W, FwdData_W
  );

  modport slave (
    input  Flush, Valid_M, PC_M, A3_M, WBSel_M, LoadType_M,
           ALUOut_M, MDUOut_M, MemRD_M,
    output A3_W, WD_W, WPC_W, FwdA3_W, FwdData_W
  );

endinterface

`default_nettype wire

// File: rtl/mw_writeback_load_ext.sv
//------------------------------------------------------------------------------
// load_ext : combinational byte/half select and sign/zero extension of a load
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_ext
  import cpu_defs_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rd[7:0];
    case (off)
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    // Halfword loads are aligned upstream, so only off[1] picks the half.
    half_sel = off[1] ? mem_rd[31:16] : mem_rd[15:0];
  end

  always_comb begin
    data = mem_rd;
    case (load_type)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'd0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'd0, half_sel};
      default: data = mem_rd;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mw_writeback.sv
//------------------------------------------------------------------------------
// mw_writeback : M/W pipeline register, write-back select and load extension.
//                Byte/half extension enabled by macro WB_LOAD_EXT_EN.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mw_writeback
  import cpu_defs_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  mw_writeback_if.slave  wb
);

  logic [31:0] pc_d,      pc_q;
  logic [4:0]  a3_d,      a3_q;
  logic [1:0]  wbsel_d,   wbsel_q;
  logic [31:0] alu_out_d, alu_out_q;
  logic [31:0] mdu_out_d, mdu_out_q;
  logic [31:0] mem_rd_d,  mem_rd_q;

  logic [31:0] load_data;
  logic [31:0] wd_w;

  // Killed or flushed slots become bubbles by zeroing only the destination.
  always_comb begin
    pc_d      = wb.PC_M;
    a3_d      = (wb.Valid_M && !wb.Flush) ? wb.A3_M : 5'd0;
    wbsel_d   = wb.WBSel_M;
    alu_out_d = wb.ALUOut_M;
    mdu_out_d = wb.MDUOut_M;
    mem_rd_d  = wb.MemRD_M;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q      <= '0;
      a3_q      <= '0;
      wbsel_q   <= '0;
      alu_out_q <= '0;
      mdu_out_q <= '0;
      mem_rd_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      a3_q      <= a3_d;
      wbsel_q   <= wbsel_d;
      alu_out_q <= alu_out_d;
      mdu_out_q <= mdu_out_d;
      mem_rd_q  <= mem_rd_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] load_type_d, load_type_q;

  always_comb begin
    load_type_d = wb.LoadType_M;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_type_q <= '0;
    end else begin
      load_type_q <= load_type_d;
    end
  end

  load_ext u_load_ext (
    .mem_rd    (mem_rd_q),
    .off       (alu_out_q[1:0]),
    .load_type (load_type_q),
    .data      (load_data)
  );
`else
  // lw-only core: memory word passes through untouched.
  assign load_data = mem_rd_q;
`endif

  always_comb begin
    wd_w = alu_out_q;
    case (wbsel_q)
      WB_ALU:  wd_w = alu_out_q;
      WB_MEM:  wd_w = load_data;
      WB_LINK: wd_w = pc_q + LINK_OFFSET;
      WB_MDU:  wd_w = mdu_out_q;
      default: wd_w = alu_out_q;
    endcase
  end

  assign wb.A3_W      = a3_q;
  assign wb.WD_W      = wd_w;
  assign wb.WPC_W     = pc_q;
  assign wb.FwdA3_W   = a3_q;
  assign wb.FwdData_W = wd_w;

endmodule

`default_nettype wire

// File: tb/tb_mw_writeback.sv
//------------------------------------------------------------------------------
// tb_mw_writeback : directed self-checking bench for mw_writeback
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mw_writeback;
  import cpu_defs_pkg::*;

`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [31:0] MRD = 32'h80FF_7F01;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  mw_writeback_if bus ();

  mw_writeback dut (
    .Clk   (Clk),
    .Reset (Reset),
    .wb    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one M-stage slot, clock it in, then scramble the M inputs so any
  // combinational leak from *_M to the outputs shows up in the checks.
  task automatic step(input logic rst, input logic flush, input logic valid,
                      input logic [4:0] a3, input logic [1:0] sel, input logic [2:0] lt,
                      input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] mdu, input logic [31:0] mrd);
    Reset          = rst;
    bus.Flush      = flush;
    bus.Valid_M    = valid;
    bus.A3_M       = a3;
    bus.WBSel_M    = sel;
    bus.LoadType_M = lt;
    bus.PC_M       = pc;
    bus.ALUOut_M   = alu;
    bus.MDUOut_M   = mdu;
    bus.MemRD_M    = mrd;
    @(posedge Clk);
    #1;
    bus.Flush      = 1'($urandom);
    bus.Valid_M    = 1'($urandom);
    bus.A3_M       = 5'($urandom);
    bus.WBSel_M    = 2'($urandom);
    bus.LoadType_M = 3'($urandom);
    bus.PC_M       = $urandom;
    bus.ALUOut_M   = $urandom;
    bus.MDUOut_M   = $urandom;
    bus.MemRD_M    = $urandom;
    #1;
  endtask

  task automatic expect_w(input string tag, input logic [4:0] a3,
                          input logic [31:0] wd, input logic [31:0] pc);
    check_eq({tag, "_a3"},     {27'd0, bus.A3_W},    {27'd0, a3});
    check_eq({tag, "_wd"},     bus.WD_W,             wd);
    check_eq({tag, "_wpc"},    bus.WPC_W,            pc);
    check_eq({tag, "_fwda3"},  {27'd0, bus.FwdA3_W}, {27'd0, a3});
    check_eq({tag, "_fwdwd"},  bus.FwdData_W,        wd);
  endtask

  initial begin
    Reset = 1'b1;
    // Reset held two edges with live-looking inputs
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1, 5'($urandom_range(1, 31)), 2'($urandom), 3'($urandom),
           $urandom, $urandom, $urandom, $urandom);
      expect_w($sformatf("reset%0d", i), 5'd0, 32'd0, 32'd0);
    end

    step(1'b0, 1'b0, 1'b1, 5'd8, WB_ALU, LD_W, 32'h3000, 32'h1234_5678, 32'h0, 32'h0);
    expect_w("alu", 5'd8, 32'h1234_5678, 32'h3000);

    step(1'b0, 1'b0, 1'b1, 5'd9, WB_MEM, LD_B, 32'h3004, 32'h1003, 32'h0, MRD);
    expect_w("lb_off3", 5'd9, EXT ? 32'hFFFF_FF80 : MRD, 32'h3004);

    step(1'b0, 1'b0, 1'b1, 5'd10, WB_MEM, LD_BU, 32'h3008, 32'h1003, 32'h0, MRD);
    expect_w("lbu_off3", 5'd10, EXT ? 32'h0000_0080 : MRD, 32'h3008);

    step(1'b0, 1'b0, 1'b1, 5'd11, WB_MEM, LD_B, 32'h300C, 32'h1001, 32'h0, MRD);
    expect_w("lb_off1", 5'd11, EXT ? 32'h0000_007F : MRD, 32'h300C);

    step(1'b0, 1'b0, 1'b1, 5'd12, WB_MEM, LD_B, 32'h3010, 32'h1002, 32'h0, MRD);
    expect_w("lb_off2", 5'd12, EXT ? 32'hFFFF_FFFF : MRD, 32'h3010);

    step(1'b0, 1'b0, 1'b1, 5'd13, WB_MEM, LD_BU, 32'h3014, 32'h1000, 32'h0, MRD);
    expect_w("lbu_off0", 5'd13, EXT ? 32'h0000_0001 : MRD, 32'h3014);

    step(1'b0, 1'b0, 1'b1, 5'd14, WB_MEM, LD_H, 32'h3018, 32'h1002, 32'h0, MRD);
    expect_w("lh_off2", 5'd14, EXT ? 32'hFFFF_80FF : MRD, 32'h3018);

    step(1'b0, 1'b0, 1'b1, 5'd15, WB_MEM, LD_H, 32'h301C, 32'h1003, 32'h0, MRD);
    expect_w("lh_off3", 5'd15, EXT ? 32'hFFFF_80FF : MRD, 32'h301C);

    step(1'b0, 1'b0, 1'b1, 5'd16, WB_MEM, LD_HU, 32'h3020, 32'h1000, 32'h0, MRD);
    expect_w("lhu_off0", 5'd16, EXT ? 32'h0000_7F01 : MRD, 32'h3020);

    step(1'b0, 1'b0, 1'b1, 5'd17, WB_MEM, LD_HU, 32'h3024, 32'h1002, 32'h0, MRD);
    expect_w("lhu_off2", 5'd17, EXT ? 32'h0000_80FF : MRD, 32'h3024);

    step(1'b0, 1'b0, 1'b1, 5'd18, WB_MEM, 3'd6, 32'h3028, 32'h1001, 32'h0, MRD);
    expect_w("ld_rsvd", 5'd18, MRD, 32'h3028);

    step(1'b0, 1'b0, 1'b1, 5'd31, WB_LINK, LD_W, 32'hFFFF_FFFC, 32'h5555_0000, 32'h0, 32'h0);
    expect_w("link_wrap", 5'd31, 32'h0000_0004, 32'hFFFF_FFFC);

    step(1'b0, 1'b0, 1'b1, 5'd2, WB_MDU, LD_W, 32'h4000, 32'h1, 32'hDEAD_BEEF, 32'h0);
    expect_w("mdu", 5'd2, 32'hDEAD_BEEF, 32'h4000);

    step(1'b0, 1'b1, 1'b1, 5'd31, WB_ALU, LD_W, 32'h4004, 32'h0000_AAAA, 32'h0, 32'h0);
    expect_w("flush", 5'd0, 32'h0000_AAAA, 32'h4004);

    step(1'b0, 1'b0, 1'b1, 5'd31, WB_ALU, LD_W, 32'h4008, 32'h0000_BBBB, 32'h0, 32'h0);
    expect_w("post_flush", 5'd31, 32'h0000_BBBB, 32'h4008);

    step(1'b0, 1'b0, 1'b0, 5'd7, WB_ALU, LD_W, 32'h400C, 32'h0000_CCCC, 32'h0, 32'h0);
    expect_w("invalid", 5'd0, 32'h0000_CCCC, 32'h400C);

    step(1'b0, 1'b0, 1'b1, 5'd5, WB_ALU, LD_W, 32'h4010, 32'h1111_1111, 32'h0, 32'h0);
    expect_w("b2b_first", 5'd5, 32'h1111_1111, 32'h4010);
    step(1'b0, 1'b0, 1'b1, 5'd5, WB_ALU, LD_W, 32'h4014, 32'h2222_2222, 32'h0, 32'h0);
    expect_w("b2b_second", 5'd5, 32'h2222_2222, 32'h4014);

    step(1'b1, 1'b1, 1'b1, 5'd20, WB_LINK, LD_B, 32'h5000, 32'h3, 32'h77, MRD);
    expect_w("rst_flush", 5'd0, 32'd0, 32'd0);

    step(1'b0, 1'b0, 1'b1, 5'd21, WB_ALU, LD_W, 32'h5004, 32'h9999_0000, 32'h0, 32'h0);
    expect_w("post_reset", 5'd21, 32'h9999_0000, 32'h5004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mw_writeback.md
# mw_writeback

- Final pipeline stage of the five-stage MIPS core: the M/W pipeline register plus write-back select and load-data extension.
- Sole driver of the general register file write port (A3, WD, WPC). The register file performs the write and the same-cycle read bypass.
- Also exposes the W-stage destination and data to the hazard/forwarding unit.

## Interface

Parameters:
- None. Encodings live in the shared package.

Ports:
- Clk  in  1  core clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all stage registers
- Flush  in  1  exception/eret flush; next W slot becomes a bubble
- Valid_M  in  1  M-stage slot holds a real instruction
- PC_M  in  32  M-stage instruction address
- A3_M  in  5  M-stage destination register (0 = no write)
- WBSel_M  in  2  write-back source: 0 ALU, 1 memory, 2 PC+8 (link), 3 MDU (HI/LO move)
- LoadType_M  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5–7 treated as lw
- ALUOut_M  in  32  ALU result; also the effective address for loads
- MDUOut_M  in  32  HI/LO read value
- MemRD_M  in  32  raw aligned word from data memory (combinational read in M)
- A3_W  out  5  register file write address (0 = no write)
- WD_W  out  32  register file write data
- WPC_W  out  32  PC of the writing instruction, for trace
- FwdA3_W  out  5  equals A3_W; forwarding-unit tap
- FwdData_W  out  32  equals WD_W; forwarding-unit tap

## Operation

- Stage registers:
  - PC
  - A3
  - WBSel
  - LoadType
  - ALUOut (address low 2 bits are taken from here)
  - MDUOut
  - MemRD
- Capture on every rising edge with no enable. The W stage never stalls.
- Captured A3 is 0 when Valid_M=0 or Flush=1. Other fields are captured as-is.
- Reset=1 at an edge: every stage register becomes 0, so A3_W=0, WD_W=0, WPC_W=0.
- Reset and Flush together: Reset result. Reset overrides everything.
- WD_W selection (combinational from stage registers):
  - WBSel 0: ALUOut
  - WBSel 1: extended load data
  - WBSel 2: PC + 8, modulo 2^32
  - WBSel 3: MDUOut
- Load extension, with byte offset off = ALUOut[1:0] (little-endian):
  - lw: MemRD
  - lb / lbu: MemRD[8·off+7 : 8·off], sign- or zero-extended to 32
  - lh / lhu: half selected by off[1], sign- or zero-extended. off[0] is ignored.
- Misaligned addresses are trapped upstream in M. This block does not check them.
- When A3_W=0, WD_W and WPC_W still reflect the stage registers. The register file ignores writes to $0.

## Timing

- Latency: M-stage values at edge N produce A3_W/WD_W/WPC_W valid throughout cycle N+1.
- The register file commits at edge N+1.
- WD_W settles combinationally from registers. There is no path from any *_M input to any output.
- Back-to-back writes to the same register on consecutive cycles are each presented once, in order.
- Flush at edge N: the cycle N+1 slot has A3_W=0. The cycle N+2 slot follows normal rules.
- Reset held for k edges: outputs stay 0 until the first edge with Reset=0 captures new values.

## Configuration

- WB_LOAD_EXT_EN defined:
  - full byte/half extension as above
  - instantiates the sub-module
- WB_LOAD_EXT_EN undefined:
  - LoadType is ignored (not registered)
  - WBSel 1 yields MemRD unmodified (lw-only core)
  - ports are unchanged

## Structure

- Shared package cpu_defs_pkg holds:
  - the WBSel encodings (WB_ALU, WB_MEM, WB_LINK, WB_MDU)
  - the LoadType encodings (LD_W, LD_B, LD_BU, LD_H, LD_HU)
  - the link offset constant 8
- One sub-module, load_ext: purely combinational, inputs (MemRD, off, LoadType), output 32-bit data.

## Test plan

- Reset=1 for 2 cycles with random *_M inputs -> A3_W=0, WD_W=0, WPC_W=0 on both cycles.
- ALU write: Valid_M=1, A3_M=8, WBSel_M=0, ALUOut_M=0x1234_5678, PC_M=0x3000 -> next cycle A3_W=8, WD_W=0x1234_5678, WPC_W=0x3000.
- Byte loads, MemRD_M=0x80FF_7F01:
  - lb, ALUOut_M=0x...3 -> WD_W=0xFFFF_FF80
  - lbu, off 3 -> 0x0000_0080
  - lb, off 1 -> 0x0000_007F
- Half loads, same MemRD_M:
  - lh, off 2 -> 0xFFFF_80FF
  - lhu, off 0 -> 0x0000_7F01
- Link and MDU:
  - WBSel=2, PC_M=0xFFFF_FFFC -> WD_W=0x0000_0004 (wrap)
  - WBSel=3, MDUOut_M=0xDEAD_BEEF -> WD_W=0xDEAD_BEEF
- Flush/Reset interaction:
  - Flush=1 with Valid_M=1, A3_M=31 -> A3_W=0 next cycle; the following instruction writes normally
  - Flush and Reset together -> all outputs 0
